// File: rtl/rs485_pkg.sv
// Shared definitions for the RS485 UART blocks: transmitter state encoding
// and bit-period helpers that the receiver will reuse.
package rs485_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        START,
        DATA,
        PARITY,
        STOP,
        TRAIL
    } tx_state_t;

    function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

    // A one-cycle bit period still needs a one-bit counter to stay legal.
    function automatic int baud_cnt_width(input int cnt_max);
        return (cnt_max > 1) ? $clog2(cnt_max) : 1;
    endfunction

endpackage

// File: rtl/rs485_baud_gen.sv
// Bit-period counter with synchronous clear; bit_end marks the last cycle of
// each period and bit_end_next predicts it one cycle ahead.
module rs485_baud_gen
    import rs485_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 9600
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end,
    output logic bit_end_next
);

    localparam int CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int CW      = baud_cnt_width(CNT_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt + CW'(1);
        if (clear || cnt == CNT_LAST) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    assign bit_end      = (cnt == CNT_LAST);
    assign bit_end_next = (cnt_next == CNT_LAST);

endmodule

// File: rtl/rs485_uart_tx.sv
// RS485 UART transmitter: ready/valid byte input, driver-enable guard times and
// frame chaining. Define RS485_TX_PARITY_EN to build the parity bit.
module rs485_uart_tx
    import rs485_pkg::*;
#(
    parameter int UART_BPS     = 9600,
    parameter int CLK_FREQ     = 50_000_000,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int GUARD_CYCLES = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] pi_data,
    input  logic       pi_valid,
    output logic       pi_ready,
    output logic       tx,
    output logic       de,
    output logic       busy,
    output logic       tx_done
);

    localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_t            state;
    tx_state_t            next_state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic [2:0]           bit_cnt;
    logic [2:0]           bit_cnt_next;
    logic [GW-1:0]        guard_cnt;
    logic [GW-1:0]        guard_cnt_next;
    logic                 bit_end;
    logic                 bit_end_next;
    logic                 baud_clear;
    logic                 accept;
    logic                 state_change;
    logic                 tx_next;
    logic                 tx_done_next;

`ifdef RS485_TX_PARITY_EN
    logic parity_bit;
`endif

    assign pi_ready     = (state == IDLE || state == TRAIL) && !sys_rst;
    assign accept       = pi_valid && pi_ready;
    assign state_change = (next_state != state);
    assign baud_clear   = state_change || (state == IDLE);

    rs485_baud_gen #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) u_baud (
        .clk          (sys_clk),
        .rst          (sys_rst),
        .clear        (baud_clear),
        .bit_end      (bit_end),
        .bit_end_next (bit_end_next)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (GUARD_CYCLES == 0) next_state = START;
                    else                   next_state = LEAD;
                end
            end
            LEAD:  if (guard_cnt == GUARD_LAST) next_state = START;
            START: if (bit_end) next_state = DATA;
            DATA: begin
                if (bit_end && bit_cnt == DATA_LAST) begin
`ifdef RS485_TX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
`ifdef RS485_TX_PARITY_EN
            PARITY: if (bit_end) next_state = STOP;
`endif
            STOP: begin
                if (bit_end && bit_cnt == STOP_LAST) begin
                    if (GUARD_CYCLES == 0) next_state = IDLE;
                    else                   next_state = TRAIL;
                end
            end
            // A byte accepted during the trail guard restarts without a new lead-in.
            TRAIL: begin
                if (accept)                         next_state = START;
                else if (guard_cnt == GUARD_LAST)   next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs are decoded from next-cycle values so they line up with the state register.
    always_comb begin
        shift_next     = shift_reg;
        bit_cnt_next   = bit_cnt;
        guard_cnt_next = '0;
        if (accept) begin
            shift_next = pi_data[DATA_BITS-1:0];
        end else if (state == DATA && bit_end) begin
            shift_next = shift_reg >> 1;
        end
        if (state_change) begin
            bit_cnt_next = '0;
        end else if (bit_end && (state == DATA || state == STOP)) begin
            bit_cnt_next = bit_cnt + 3'd1;
        end
        if (!state_change && (state == LEAD || state == TRAIL)) begin
            guard_cnt_next = guard_cnt + GW'(1);
        end
        case (next_state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef RS485_TX_PARITY_EN
            PARITY:  tx_next = parity_bit;
`endif
            default: tx_next = 1'b1;
        endcase
        tx_done_next = (next_state == STOP) && bit_end_next && (bit_cnt_next == STOP_LAST);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            guard_cnt <= '0;
            tx        <= 1'b1;
            de        <= 1'b0;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= next_state;
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt_next;
            guard_cnt <= guard_cnt_next;
            tx        <= tx_next;
            de        <= (next_state != IDLE);
            busy      <= (next_state != IDLE);
            tx_done   <= tx_done_next;
        end
    end

`ifdef RS485_TX_PARITY_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            parity_bit <= 1'b0;
        end else if (accept) begin
            parity_bit <= (PARITY_ODD != 0) ? ~^pi_data[DATA_BITS-1:0] : ^pi_data[DATA_BITS-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_rs485_uart_tx.sv
// Self-checking bench for rs485_uart_tx: an 8N1/even instance and a 5-bit/2-stop/odd
// instance, compared cycle by cycle against a frame-level model. Honours RS485_TX_PARITY_EN.
module tb_rs485_uart_tx;

    localparam int G   = 4;
    localparam int BIT = 10;
`ifdef RS485_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    logic       clk = 1'b0;
    logic       sys_rst;
    logic [7:0] data8, data5;
    logic       valid8, valid5;
    logic       ready8, tx8, de8, busy8, done8;
    logic       ready5, tx5, de5, busy5, done5;

    int n_checks = 0;
    int n_fail   = 0;

    bit model_bits [2][16];
    int model_nbits [2];
    int model_start [2];
    int model_n;
    int model_last_k;
    int model_abort_k;

    always #5 clk = ~clk;

    rs485_uart_tx #(
        .UART_BPS (100_000), .CLK_FREQ (1_000_000), .DATA_BITS (8),
        .STOP_BITS (1), .PARITY_ODD (0), .GUARD_CYCLES (G)
    ) dut (
        .sys_clk (clk), .sys_rst (sys_rst), .pi_data (data8), .pi_valid (valid8),
        .pi_ready (ready8), .tx (tx8), .de (de8), .busy (busy8), .tx_done (done8)
    );

    rs485_uart_tx #(
        .UART_BPS (100_000), .CLK_FREQ (1_000_000), .DATA_BITS (5),
        .STOP_BITS (2), .PARITY_ODD (1), .GUARD_CYCLES (G)
    ) dut5 (
        .sys_clk (clk), .sys_rst (sys_rst), .pi_data (data5), .pi_valid (valid5),
        .pi_ready (ready5), .tx (tx5), .de (de5), .busy (busy5), .tx_done (done5)
    );

    function automatic int frame_cycles(input int dbits, input int sbits);
        return (1 + dbits + PBITS + sbits) * BIT;
    endfunction

    // Expected bit list of one frame: start, data LSB first, optional parity, stops.
    task automatic model_frame(input int idx, input logic [7:0] d, input int dbits,
                               input int sbits, input bit odd, input int start);
        int ones;
        int n;
        ones = 0;
        model_bits[idx][0] = 1'b0;
        for (int i = 0; i < dbits; i++) begin
            model_bits[idx][1 + i] = d[i];
            ones += int'(d[i]);
        end
        n = 1 + dbits;
        if (PBITS == 1) begin
            if (odd) model_bits[idx][n] = ((ones % 2) == 0);
            else     model_bits[idx][n] = ((ones % 2) == 1);
            n++;
        end
        for (int s = 0; s < sbits; s++) begin
            model_bits[idx][n] = 1'b1;
            n++;
        end
        model_nbits[idx] = n;
        model_start[idx] = start;
    endtask

    // Expected {tx, de, busy, tx_done} in cycle k after the first accept edge.
    function automatic logic [3:0] model_vec(input int k);
        logic t;
        logic e;
        logic dn;
        t  = 1'b1;
        dn = 1'b0;
        if (k > model_abort_k) return 4'b1000;
        e = (k >= 1 && k <= model_last_k);
        for (int f = 0; f < model_n; f++) begin
            if (k >= model_start[f] && k < model_start[f] + model_nbits[f] * BIT) begin
                t = model_bits[f][(k - model_start[f]) / BIT];
                if (k == model_start[f] + model_nbits[f] * BIT - 1) dn = 1'b1;
            end
        end
        return {t, e, e, dn};
    endfunction

    task automatic check_output(input string tag, input int k, input logic [3:0] obs,
                                input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    task automatic drive(input bit use5, input logic v, input logic [7:0] d);
        if (use5) begin
            valid5 = v;
            data5  = d;
        end else begin
            valid8 = v;
            data8  = d;
        end
    endtask

    // Offers a byte and returns just after the edge that accepts it.
    task automatic apply_stimulus(input bit use5, input logic [7:0] d);
        int   w;
        logic rdy;
        @(negedge clk);
        drive(use5, 1'b1, d);
        w   = 0;
        rdy = use5 ? ready5 : ready8;
        while (rdy !== 1'b1 && w < 1000) begin
            @(negedge clk);
            w++;
            rdy = use5 ? ready5 : ready8;
        end
        check_output("accept_wait", w, {3'b000, rdy}, 4'b0001);
        @(posedge clk);
        #1 drive(use5, 1'b0, 8'h00);
    endtask

    task automatic check_frame(input bit use5, input int ncycles, input int dis_lo,
                               input int dis_hi, input int chain_k, input logic [7:0] chain_d,
                               input int rst_k);
        logic [3:0] obs;
        logic       rdy;
        int         pulses;
        int         exp_pulses;
        pulses     = 0;
        exp_pulses = 0;
        for (int f = 0; f < model_n; f++) begin
            if (model_start[f] + model_nbits[f] * BIT - 1 <= model_abort_k) exp_pulses++;
        end
        for (int k = 1; k <= ncycles; k++) begin
            @(negedge clk);
            obs = use5 ? {tx5, de5, busy5, done5} : {tx8, de8, busy8, done8};
            rdy = use5 ? ready5 : ready8;
            check_output("frame", k, obs, model_vec(k));
            if (obs[0] === 1'b1) pulses++;
            if (dis_hi > 0 && k >= dis_lo && k < dis_hi) begin
                check_output("ready_held_off", k, {3'b000, rdy}, 4'b0000);
                drive(use5, 1'b1, 8'($urandom_range(0, 255)));
            end
            if (dis_hi > 0 && k == dis_hi) drive(use5, 1'b0, 8'h00);
            if (chain_k > 0 && k == chain_k) begin
                check_output("ready_trail", k, {3'b000, rdy}, 4'b0001);
                drive(use5, 1'b1, chain_d);
            end
            if (chain_k > 0 && k == chain_k + 1) drive(use5, 1'b0, 8'h00);
            if (rst_k > 0 && k == rst_k) sys_rst = 1'b1;
            if (rst_k > 0 && k == rst_k + 1) sys_rst = 1'b0;
        end
        check_output("done_pulses", 0, 4'(pulses), 4'(exp_pulses));
        rdy = use5 ? ready5 : ready8;
        check_output("ready_idle", 0, {3'b000, rdy}, 4'b0001);
    endtask

    task automatic run_single(input bit use5, input logic [7:0] d, input bit disturb);
        int dbits;
        int sbits;
        int f;
        dbits = use5 ? 5 : 8;
        sbits = use5 ? 2 : 1;
        f     = frame_cycles(dbits, sbits);
        model_n = 1;
        model_frame(0, d, dbits, sbits, use5, G + 1);
        model_last_k  = 2 * G + f;
        model_abort_k = 1_000_000;
        apply_stimulus(use5, d);
        check_frame(use5, 2 * G + f + 3, disturb ? G + 1 : 0, disturb ? G + f : 0,
                    0, 8'h00, 0);
    endtask

    initial begin
        int f8;
        f8      = frame_cycles(8, 1);
        sys_rst = 1'b1;
        valid8  = 1'b0;
        valid5  = 1'b0;
        data8   = 8'h00;
        data5   = 8'h00;

        $display("[TB] reset state");
        repeat (3) @(negedge clk);
        check_output("reset_out8", 0, {tx8, de8, busy8, done8}, 4'b1000);
        check_output("reset_out5", 0, {tx5, de5, busy5, done5}, 4'b1000);
        check_output("reset_ready8", 0, {3'b000, ready8}, 4'b0000);
        check_output("reset_ready5", 0, {3'b000, ready5}, 4'b0000);
        sys_rst = 1'b0;
        @(negedge clk);
        check_output("idle_ready8", 0, {3'b000, ready8}, 4'b0001);
        check_output("idle_ready5", 0, {3'b000, ready5}, 4'b0001);

        $display("[TB] 8-bit frames");
        run_single(1'b0, 8'hA5, 1'b0);
        for (int i = 0; i < 3; i++) run_single(1'b0, 8'($urandom_range(0, 255)), 1'b0);

        $display("[TB] 5-bit two-stop frames");
        run_single(1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < 2; i++) run_single(1'b1, 8'($urandom_range(0, 255)), 1'b0);

        $display("[TB] chained frame accepted in trail");
        model_n = 2;
        model_frame(0, 8'h55, 8, 1, 1'b0, G + 1);
        model_frame(1, 8'h3C, 8, 1, 1'b0, G + f8 + 2);
        model_last_k  = 2 * G + 2 * f8 + 1;
        model_abort_k = 1_000_000;
        apply_stimulus(1'b0, 8'h55);
        check_frame(1'b0, model_last_k + 3, 0, 0, G + f8 + 1, 8'h3C, 0);

        $display("[TB] valid held with changing data during frame");
        run_single(1'b0, 8'($urandom_range(0, 255)), 1'b1);
        run_single(1'b1, 8'($urandom_range(0, 255)), 1'b1);

        $display("[TB] reset in the middle of data");
        model_n = 1;
        model_frame(0, 8'($urandom_range(0, 255)), 8, 1, 1'b0, G + 1);
        model_last_k  = 2 * G + f8;
        model_abort_k = G + BIT + 35;
        apply_stimulus(1'b0, 8'hC3);
        model_frame(0, 8'hC3, 8, 1, 1'b0, G + 1);
        check_frame(1'b0, model_abort_k + 5, 0, 0, 0, 8'h00, model_abort_k);
        run_single(1'b0, 8'($urandom_range(0, 255)), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rs485_uart_tx.md
# rs485_uart_tx

Parametrised UART transmitter for the RS485 link, successor of the fixed 8N1 transmitter. It serialises one byte per ready/valid handshake with configurable data width, stop bits and optional parity. It drives the transceiver driver-enable (`de`) with programmable lead and trail guard times, and chains back-to-back frames without releasing the bus. It sits between the loopback/command logic and the RS485 PHY pins.

## Interface
- `UART_BPS`, 9600, baud rate.
- `CLK_FREQ`, 50_000_000, `sys_clk` frequency in Hz.
- `DATA_BITS`, 8, data bits per frame; legal values 5..8.
- `STOP_BITS`, 1, stop bits per frame; legal values 1 or 2.
- `PARITY_ODD`, 0, selects odd parity (1) or even parity (0); used only with `RS485_TX_PARITY_EN`.
- `GUARD_CYCLES`, 16, `sys_clk` cycles of `de` before the start bit and after the last stop bit; 0 is legal.

Ports:
- `sys_clk`  in  1  system clock.
- `sys_rst`  in  1  reset; synchronous, active-high.
- `pi_data`  in  8  byte to send; bits above `DATA_BITS-1` are ignored.
- `pi_valid`  in  1  `pi_data` is valid.
- `pi_ready`  out  1  transmitter accepts a byte this cycle.
- `tx`  out  1  serial line, idle high, LSB first.
- `de`  out  1  RS485 driver enable.
- `busy`  out  1  a frame or guard interval is in progress.
- `tx_done`  out  1  one-cycle pulse at the end of each frame's final stop bit.

## Operation
- Bit period: `BAUD_CNT_MAX = CLK_FREQ/UART_BPS` cycles (integer division). The baud counter is `$clog2(BAUD_CNT_MAX)` bits wide and counts 0..`BAUD_CNT_MAX`-1. It is held at 0 in IDLE and restarts at every state change.
- Accept: `pi_valid && pi_ready` at a rising edge. `pi_data` is copied into an internal shift register, and the parity bit is computed from the masked data at the same edge. Later changes to `pi_data` have no effect on the frame.
- States:
  - IDLE: `pi_ready`=1. On accept, go to LEAD, or directly to START if `GUARD_CYCLES`=0.
  - LEAD: lasts `GUARD_CYCLES` cycles, then START.
  - START: one bit period, `tx`=0.
  - DATA: `DATA_BITS` bit periods, LSB first, shifting right once per bit period.
  - PARITY: one bit period. Exists only with the macro defined.
  - STOP: `STOP_BITS` bit periods, `tx`=1. `tx_done` pulses in the last cycle of STOP.
  - TRAIL: `pi_ready`=1. An accept here goes straight to START and skips LEAD. Otherwise, after `GUARD_CYCLES` cycles, go to IDLE (also when `GUARD_CYCLES`=0, after zero cycles, i.e. STOP goes directly to IDLE).
- `pi_ready` = state is IDLE or TRAIL; forced 0 while `sys_rst`=1.
- `de` = 1 in every state except IDLE; it stays 1 across chained frames.
- `busy` = state is not IDLE.
- Parity: even → `^data`; odd → `~^data`, over the `DATA_BITS` LSBs.

## Timing
- All outputs are registered except `pi_ready`, which is decoded from the state register.
- Reset values, held while `sys_rst`=1: `tx`=1, `de`=0, `busy`=0, `tx_done`=0, state IDLE, counters 0.
- Accept at edge N gives `de`=1 and `busy`=1 from cycle N+1.
- `tx` falls at cycle N+1+`GUARD_CYCLES`.
- Frame length is (1 + `DATA_BITS` + P + `STOP_BITS`)·`BAUD_CNT_MAX` cycles, where P = 1 with parity and 0 without.
- `de` falls `GUARD_CYCLES` cycles after the end of the last stop bit.
- Chained accept in TRAIL at edge M: the start bit begins at cycle M+1, and `de` never drops.
- Reset mid-frame: on the next edge the frame is aborted, `tx`=1 and `de`=0. No `tx_done` is produced.
- `pi_valid` asserted in any other state is held off: `pi_ready`=0 and no data is lost upstream.

## Configuration
- `RS485_TX_PARITY_EN` defined: the PARITY state and parity register are built, and `PARITY_ODD` selects the sense.
- `RS485_TX_PARITY_EN` undefined: no parity logic is built, DATA goes directly to STOP, and `PARITY_ODD` is ignored.

## Structure
- Shared package `rs485_pkg`:
  - state enum `tx_state_t` (IDLE, LEAD, START, DATA, PARITY, STOP, TRAIL).
  - function computing `BAUD_CNT_MAX` and its counter width, reused by the future receiver.
- Sub-module `rs485_baud_gen`: baud counter with synchronous clear, producing a one-cycle `bit_end` pulse.
- The FSM, shift register and outputs stay in the top module.

## Test plan
Bench parameters: `CLK_FREQ`=1_000_000, `UART_BPS`=100_000 (10 cycles/bit), `GUARD_CYCLES`=4.
1. 8N1, send 0xA5 → `de` rises 4 cycles before `tx` falls. `tx` carries 0,1,0,1,0,0,1,0,1,1, 10 cycles per bit. One `tx_done` pulse. `de` falls 4 cycles after the stop bit ends.
2. Parity macro on, even parity, 0xA5 → parity bit 0. With `PARITY_ODD`=1 → parity bit 1. Frame length 110 cycles.
3. `DATA_BITS`=5, `STOP_BITS`=2, send 0xFF → data 1,1,1,1,1, then 20 cycles high. Bits 7:5 are ignored. Total 80 cycles.
4. Assert `pi_valid` with 0x3C during TRAIL of a 0x55 frame → accepted. The 0x3C start bit follows immediately, `de` stays high throughout, and two `tx_done` pulses occur.
5. Hold `pi_valid` with changing `pi_data` during DATA → `pi_ready`=0 and the transmitted byte is unchanged.
6. Assert `sys_rst` for 1 cycle in the middle of DATA → next cycle `tx`=1, `de`=0, `busy`=0, no `tx_done`. A new byte sends correctly afterwards.
